// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front end: frame geometry defaults,
// RGB565 pixel layout and capture FSM state encoding.
package cam_pkg;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;

    // Output coordinate widths
    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    // Internal x / line counters are one bit wider so they can hold the saturation value
    localparam int unsigned CNT_W = 11;

    // RGB565: R = [15:11], G = [10:5], B = [4:0]
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Capture FSM encoding
    typedef logic [1:0] cam_state_t;
    localparam cam_state_t WAIT_SYNC = 2'd0;
    localparam cam_state_t BLANK     = 2'd1;
    localparam cam_state_t ACTIVE    = 2'd2;

    // First byte of the pair on the bus is the high byte of the pixel
    function automatic rgb565_t pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

    // A line is malformed when it did not deliver exactly h_limit whole pixels
    function automatic logic line_is_bad(input logic [CNT_W-1:0] x,
                                         input logic             phase,
                                         input logic             overflow,
                                         input logic [CNT_W-1:0] h_limit);
        return (x != h_limit) || phase || overflow;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-stage synchronizer for asynchronous camera inputs with rising/falling
// edge detection on the synchronized value.
module cam_sync_edge #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Never fewer than two flops in front of the first consumer
    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]        prev_q;

    // Shift chain plus one extra flop holding the previous synchronized value
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], din};
            prev_q <= sync_q[N-1];
        end
    end

    assign q    = sync_q[N-1];
    assign rise = sync_q[N-1] & ~prev_q;
    assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/cam_pixel_assembler.sv
// Camera capture front end: oversamples the OV-style bus on inclk, assembles
// RGB565 byte pairs into pixels with x/y coordinates and emits frame/line events.
module cam_pixel_assembler
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           inclk,
    input  logic           rst,
    input  logic           apclk,
    input  logic           ahref,
    input  logic           avsync,
    input  logic [7:0]     adata,
    output logic           pix_valid,
    output logic [15:0]    pix_rgb,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           frame_start,
    output logic           frame_done,
    output logic           line_err,
    output logic [Y_W-1:0] lines_seen
);

    localparam logic [CNT_W-1:0] H_LIMIT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LIMIT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchronized camera inputs
    logic       pclk_sync, pclk_rise, pclk_fall_unused;
    logic       href_sync, href_rise_unused, href_fall_unused;
    logic       vsync_sync, vsync_rise, vsync_fall;
    logic [7:0] data_sync, data_rise_unused, data_fall_unused;

    cam_sync_edge #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_pclk (
        .clk  (inclk),
        .rst  (rst),
        .din  (apclk),
        .q    (pclk_sync),
        .rise (pclk_rise),
        .fall (pclk_fall_unused)
    );

    cam_sync_edge #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_href (
        .clk  (inclk),
        .rst  (rst),
        .din  (ahref),
        .q    (href_sync),
        .rise (href_rise_unused),
        .fall (href_fall_unused)
    );

    cam_sync_edge #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_vsync (
        .clk  (inclk),
        .rst  (rst),
        .din  (avsync),
        .q    (vsync_sync),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    cam_sync_edge #(
        .WIDTH  (8),
        .STAGES (SYNC_STAGES)
    ) u_sync_data (
        .clk  (inclk),
        .rst  (rst),
        .din  (adata),
        .q    (data_sync),
        .rise (data_rise_unused),
        .fall (data_fall_unused)
    );

    // State
    cam_state_t       state_q, state_d;
    logic             href_q, href_d;        // href as seen at the previous apclk sample
    logic             in_line_q, in_line_d;  // current line is inside the active window
    logic             phase_q, phase_d;      // 1 = high byte held, waiting for low byte
    logic             ovf_q, ovf_d;          // line delivered more than H_ACTIVE pixels
    logic [7:0]       hi_q, hi_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;

    // Registered outputs
    logic             pix_valid_q, pix_valid_d;
    rgb565_t          pix_rgb_q, pix_rgb_d;
    logic [X_W-1:0]   pix_x_q, pix_x_d;
    logic [Y_W-1:0]   pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             line_err_q, line_err_d;
    logic [Y_W-1:0]   lines_seen_q, lines_seen_d;

    logic             close_line;

    // Next-state: byte assembly, line bookkeeping and frame FSM
    always_comb begin
        state_d       = state_q;
        href_d        = href_q;
        in_line_d     = in_line_q;
        phase_d       = phase_q;
        ovf_d         = ovf_q;
        hi_d          = hi_q;
        x_d           = x_q;
        line_cnt_d    = line_cnt_q;
        pix_valid_d   = 1'b0;
        pix_rgb_d     = pix_rgb_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = 1'b0;
        lines_seen_d  = lines_seen_q;
        close_line    = 1'b0;

        // href history is tracked in every state so a line already running when
        // the frame opens is never mistaken for a fresh line start
        if (pclk_rise) begin
            href_d = href_sync;
        end

        if (pclk_rise && state_q == ACTIVE) begin
            if (href_sync && !href_q) begin
                // Line start; the first sampled byte is already a high byte
                in_line_d = (line_cnt_q < V_LIMIT);
                x_d       = '0;
                ovf_d     = 1'b0;
                hi_d      = data_sync;
                phase_d   = 1'b1;
            end else if (href_sync && in_line_q) begin
                if (!phase_q) begin
                    hi_d    = data_sync;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (x_q < H_LIMIT) begin
                        pix_valid_d = 1'b1;
                        pix_rgb_d   = pack_pixel(hi_q, data_sync);
                        pix_x_d     = x_q[X_W-1:0];
                        pix_y_d     = line_cnt_q[Y_W-1:0];
                        x_d         = x_q + CNT_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end else if (!href_sync && href_q && in_line_q) begin
                close_line = 1'b1;
            end
        end

        // avsync rising mid-line closes the line before the frame ends
        if (state_q == ACTIVE && vsync_rise && in_line_d) begin
            close_line = 1'b1;
        end

        if (close_line) begin
            line_err_d = line_is_bad(x_d, phase_d, ovf_d, H_LIMIT);
            line_cnt_d = (line_cnt_q < V_LIMIT) ? line_cnt_q + CNT_ONE : line_cnt_q;
            in_line_d  = 1'b0;
            phase_d    = 1'b0;
        end

        case (state_q)
            WAIT_SYNC: begin
                // Only a full blanking interval can open a frame
                if (vsync_sync) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (vsync_fall) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    line_cnt_d    = '0;
                    x_d           = '0;
                    phase_d       = 1'b0;
                    ovf_d         = 1'b0;
                    in_line_d     = 1'b0;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    state_d      = BLANK;
                    frame_done_d = 1'b1;
                    lines_seen_d = line_cnt_d[Y_W-1:0];
                end
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q       <= WAIT_SYNC;
            href_q        <= 1'b0;
            in_line_q     <= 1'b0;
            phase_q       <= 1'b0;
            ovf_q         <= 1'b0;
            hi_q          <= '0;
            x_q           <= '0;
            line_cnt_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_rgb_q     <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            lines_seen_q  <= '0;
        end else begin
            state_q       <= state_d;
            href_q        <= href_d;
            in_line_q     <= in_line_d;
            phase_q       <= phase_d;
            ovf_q         <= ovf_d;
            hi_q          <= hi_d;
            x_q           <= x_d;
            line_cnt_q    <= line_cnt_d;
            pix_valid_q   <= pix_valid_d;
            pix_rgb_q     <= pix_rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            lines_seen_q  <= lines_seen_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign lines_seen  = lines_seen_q;

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Directed bench for cam_pixel_assembler on a reduced 8x4 frame geometry.
module tb_cam_pixel_assembler;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned SS = 2;

    logic        inclk  = 1'b0;
    logic        rst    = 1'b1;
    logic        apclk  = 1'b0;
    logic        ahref  = 1'b0;
    logic        avsync = 1'b0;
    logic [7:0]  adata  = 8'h00;
    logic        pix_valid;
    logic [15:0] pix_rgb;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;
    logic [8:0]  lines_seen;

    cam_pixel_assembler #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SYNC_STAGES (SS)
    ) dut (
        .inclk       (inclk),
        .rst         (rst),
        .apclk       (apclk),
        .ahref       (ahref),
        .avsync      (avsync),
        .adata       (adata),
        .pix_valid   (pix_valid),
        .pix_rgb     (pix_rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .lines_seen  (lines_seen)
    );

    always #5 inclk = ~inclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Event recorder, sampled away from the active edge
    int          n_pix   = 0;
    int          n_err   = 0;
    int          n_fs    = 0;
    int          n_fd    = 0;
    int          n_clash = 0;
    logic [15:0] rgb_log[$];
    logic [9:0]  x_log[$];
    logic [8:0]  y_log[$];

    always @(negedge inclk) begin
        if (pix_valid) begin
            n_pix++;
            rgb_log.push_back(pix_rgb);
            x_log.push_back(pix_x);
            y_log.push_back(pix_y);
            if (frame_start) n_clash++;
        end
        if (line_err)    n_err++;
        if (frame_start) n_fs++;
        if (frame_done)  n_fd++;
    end

    int b_pix, b_err, b_fs, b_fd;

    task automatic snap();
        b_pix = n_pix;
        b_err = n_err;
        b_fs  = n_fs;
        b_fd  = n_fd;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One apclk period of 8 inclk; data and href change while apclk is low
    task automatic pclk_cycle(input logic href, input logic [7:0] d);
        apclk = 1'b0;
        ahref = href;
        adata = d;
        repeat (4) @(negedge inclk);
        apclk = 1'b1;
        repeat (4) @(negedge inclk);
    endtask

    // Bytes count 0,1,2,... so pixel k of a line is {2k, 2k+1}
    task automatic send_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) pclk_cycle(1'b1, 8'(i));
        pclk_cycle(1'b0, 8'h00);
        pclk_cycle(1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pclk_cycle(1'b0, 8'h00);
    endtask

    initial begin
        repeat (4) @(negedge inclk);

        // Reset values
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'h0);
        check("rst_pix_x", 32'(pix_x), 32'h0);
        check("rst_pix_y", 32'(pix_y), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_line_err", 32'(line_err), 32'h0);
        check("rst_lines_seen", 32'(lines_seen), 32'h0);

        // Released mid-frame: lines before the first blanking are ignored
        rst = 1'b0;
        snap();
        send_line(16);
        send_line(16);
        check("prestart_pix", 32'(n_pix - b_pix), 32'd0);
        check("prestart_fs", 32'(n_fs - b_fs), 32'd0);
        check("prestart_err", 32'(n_err - b_err), 32'd0);

        // Frame 1: clean 8x4 frame
        snap();
        avsync = 1'b1;
        idle(3);
        avsync = 1'b0;
        idle(2);
        check("f1_frame_start", 32'(n_fs - b_fs), 32'd1);
        snap();
        for (int l = 0; l < 4; l++) send_line(16);
        avsync = 1'b1;
        idle(3);
        check("f1_pix_count", 32'(n_pix - b_pix), 32'd32);
        check("f1_line_err", 32'(n_err - b_err), 32'd0);
        check("f1_frame_done", 32'(n_fd - b_fd), 32'd1);
        check("f1_lines_seen", 32'(lines_seen), 32'd4);
        check("f1_p0_rgb", 32'(rgb_log[b_pix]), 32'h0001);
        check("f1_p0_x", 32'(x_log[b_pix]), 32'd0);
        check("f1_p0_y", 32'(y_log[b_pix]), 32'd0);
        check("f1_p1_rgb", 32'(rgb_log[b_pix + 1]), 32'h0203);
        check("f1_p1_x", 32'(x_log[b_pix + 1]), 32'd1);
        check("f1_p7_rgb", 32'(rgb_log[b_pix + 7]), 32'h0E0F);
        check("f1_p7_x", 32'(x_log[b_pix + 7]), 32'd7);
        check("f1_p8_rgb", 32'(rgb_log[b_pix + 8]), 32'h0001);
        check("f1_p8_x", 32'(x_log[b_pix + 8]), 32'd0);
        check("f1_p8_y", 32'(y_log[b_pix + 8]), 32'd1);
        check("f1_last_x", 32'(x_log[b_pix + 31]), 32'd7);
        check("f1_last_y", 32'(y_log[b_pix + 31]), 32'd3);

        // Frame 2: short line, good line, long line, good line, two extra lines
        snap();
        avsync = 1'b0;
        idle(2);
        check("f2_frame_start", 32'(n_fs - b_fs), 32'd1);
        snap();
        send_line(15);
        check("short_pix", 32'(n_pix - b_pix), 32'd7);
        check("short_err", 32'(n_err - b_err), 32'd1);
        check("short_last_x", 32'(x_log[n_pix - 1]), 32'd6);
        snap();
        send_line(16);
        check("after_short_pix", 32'(n_pix - b_pix), 32'd8);
        check("after_short_err", 32'(n_err - b_err), 32'd0);
        check("after_short_x0", 32'(x_log[b_pix]), 32'd0);
        check("after_short_y", 32'(y_log[b_pix]), 32'd1);
        snap();
        send_line(20);
        check("long_pix", 32'(n_pix - b_pix), 32'd8);
        check("long_err", 32'(n_err - b_err), 32'd1);
        check("long_last_x", 32'(x_log[n_pix - 1]), 32'd7);
        check("long_y", 32'(y_log[n_pix - 1]), 32'd2);
        snap();
        send_line(16);
        check("row3_pix", 32'(n_pix - b_pix), 32'd8);
        check("row3_y", 32'(y_log[n_pix - 1]), 32'd3);
        snap();
        send_line(16);
        send_line(16);
        check("extra_rows_pix", 32'(n_pix - b_pix), 32'd0);
        check("extra_rows_err", 32'(n_err - b_err), 32'd0);
        snap();
        avsync = 1'b1;
        idle(3);
        check("f2_frame_done", 32'(n_fd - b_fd), 32'd1);
        check("f2_lines_seen", 32'(lines_seen), 32'd4);

        // Frame 3: avsync rises in the middle of the second line
        avsync = 1'b0;
        idle(2);
        send_line(16);
        snap();
        for (int i = 0; i < 11; i++) pclk_cycle(1'b1, 8'(i));
        avsync = 1'b1;
        pclk_cycle(1'b1, 8'd11);
        pclk_cycle(1'b1, 8'd12);
        idle(3);
        check("cut_pix", 32'(n_pix - b_pix), 32'd5);
        check("cut_err", 32'(n_err - b_err), 32'd1);
        check("cut_frame_done", 32'(n_fd - b_fd), 32'd1);
        check("cut_lines_seen", 32'(lines_seen), 32'd2);

        // Frame 4 recovers cleanly from row 0
        snap();
        avsync = 1'b0;
        idle(2);
        send_line(16);
        check("f4_frame_start", 32'(n_fs - b_fs), 32'd1);
        check("f4_pix", 32'(n_pix - b_pix), 32'd8);
        check("f4_err", 32'(n_err - b_err), 32'd0);
        check("f4_x0", 32'(x_log[b_pix]), 32'd0);
        check("f4_y0", 32'(y_log[b_pix]), 32'd0);

        // Reset mid-frame clears held outputs on the next cycle
        rst = 1'b1;
        @(negedge inclk);
        check("midrst_pix_x", 32'(pix_x), 32'd0);
        check("midrst_pix_rgb", 32'(pix_rgb), 32'h0);
        check("midrst_lines_seen", 32'(lines_seen), 32'd0);
        rst = 1'b0;
        snap();
        send_line(16);
        check("midrst_no_capture", 32'(n_pix - b_pix), 32'd0);
        avsync = 1'b1;
        idle(3);
        avsync = 1'b0;
        idle(2);
        send_line(16);
        check("midrst_fs", 32'(n_fs - b_fs), 32'd1);
        check("midrst_pix", 32'(n_pix - b_pix), 32'd8);
        check("midrst_x0", 32'(x_log[b_pix]), 32'd0);
        check("midrst_y0", 32'(y_log[b_pix]), 32'd0);

        check("pix_vs_frame_start", 32'(n_clash), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pixel_assembler.md
Name: cam_pixel_assembler

Overview:
Front-end capture stage that sits directly upstream of the hue and ball-detection logic. It oversamples the OV-style camera bus (apclk, ahref, avsync, adata) on the system clock and assembles RGB565 byte pairs into 16-bit pixels. Each pixel carries x/y coordinates, and the block also emits frame and line event strobes. All outputs are in the inclk domain; apclk is treated as data, not as a clock.

Parameters:
H_ACTIVE, 640, active pixels per line (bytes per line = 2*H_ACTIVE)
V_ACTIVE, 480, active lines per frame
SYNC_STAGES, 2, flip-flop stages on every camera input (minimum 2)

Ports:
inclk  in  1  system clock; at least 4x the apclk frequency
rst  in  1  synchronous, active-high reset
apclk  in  1  camera pixel clock, asynchronous
ahref  in  1  line valid, high during active bytes
avsync  in  1  frame sync; high = vertical blanking
adata  in  8  camera byte; changes on apclk falling edge
pix_valid  out  1  one-cycle strobe; pix_rgb/pix_x/pix_y are valid
pix_rgb  out  16  RGB565 pixel; first byte of the pair = [15:8]
pix_x  out  10  column 0..H_ACTIVE-1
pix_y  out  9  row 0..V_ACTIVE-1
frame_start  out  1  one-cycle strobe when avsync falls (synced)
frame_done  out  1  one-cycle strobe when avsync rises after an ACTIVE frame
line_err  out  1  one-cycle strobe on a malformed line
lines_seen  out  9  line count of the last completed frame; held until the next frame_done

Behaviour:
- Reset: all outputs 0. FSM = WAIT_SYNC. Counters, phase and byte register cleared. Synchronizer flops cleared to 0.
- Synchronizer: apclk, ahref, avsync and adata each pass through SYNC_STAGES flops. pclk_rise is asserted when the synced apclk is 1 and its previous value is 0.
- Sampling: on the pclk_rise cycle, synced ahref and adata are the sampled values. No other cycle samples data.
- FSM states:
  - WAIT_SYNC: ignores everything until synced avsync = 1, then moves to BLANK. This guarantees no partial first frame after reset.
  - BLANK: on the avsync falling edge, pulse frame_start, set y=0, move to ACTIVE.
  - ACTIVE: on the avsync rising edge, pulse frame_done, load lines_seen = line count, move to BLANK.
- Line handling (ACTIVE only), on href edges detected at pclk_rise:
  - href 0->1: x=0, phase=0.
  - While href=1, each sample with phase=0 stores the byte as the high byte and sets phase=1.
  - Each sample with phase=1 forms the pixel {hi, byte}. pix_valid pulses the next inclk cycle with the current x/y, then x increments and phase=0.
- href 1->0 (line end):
  - line_err pulses if x != H_ACTIVE or phase=1.
  - The line counter increments, saturating at V_ACTIVE.
  - y takes the next row value.
- Overflow drops:
  - Pixels with x >= H_ACTIVE are dropped (no pix_valid); line_err then pulses at line end.
  - Lines with y >= V_ACTIVE are dropped entirely; no further line_err for them.
- Latency: a byte at the adata pin produces pix_valid SYNC_STAGES+2 inclk cycles after the apclk rising edge that presents its second byte (±1 cycle synchronizer uncertainty).
- Simultaneous events:
  - avsync rising while href=1: the line is closed as at a line end, then frame_done pulses. Both strobes are allowed in the same cycle.
  - pix_valid never coincides with frame_start.
- Blanking: href pulses during BLANK or WAIT_SYNC are ignored, with no line_err.
- Reset asserted mid-frame: next cycle all outputs are 0 and the FSM is in WAIT_SYNC; capture resumes only after a full blanking interval is seen.

Decomposition:
- Shared package cam_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults
  - RGB565 field slices: R = [15:11], G = [10:5], B = [4:0]
  - FSM state typedef {WAIT_SYNC, BLANK, ACTIVE}
- One natural sub-module, cam_sync_edge: parameterized-width SYNC_STAGES synchronizer plus rising/falling edge detect, instantiated for apclk/ahref/avsync (edges) and adata (width 8, no edge).

Test Plan:
- Reset, then one frame with data counting 0x00,0x01,... per line (apclk = 16 inclk periods, 640x480) -> exactly 307200 pix_valid. Pixel (0,y) = 0x0001, (1,y) = 0x0203, (127,y) = 0xFEFF. frame_start once, frame_done once, lines_seen = 480, line_err never.
- Reset released while avsync=0 in mid-frame -> no pix_valid until after the next avsync high->low. First pixel has x=0, y=0.
- Line shortened to 1279 bytes -> 639 pix_valid for that line, then line_err pulses once at href fall. The next line starts at x=0 and is error-free.
- Line lengthened to 1290 bytes -> 640 pix_valid (x max 639), line_err pulses once.
- Frame with 482 lines -> 480 rows emitted (y max 479), lines_seen = 480, no pix_valid for rows 480/481.
- avsync rises while href=1 at byte 700 -> line_err and frame_done pulse. Next frame_start resets y to 0 and capture continues normally.
